// File: rtl/serial_load_sequencer_pkg.sv
// Shared types for the serial load sequencer and the 4-bit load/clear register stage.
// State encoding and the default frame width.
package serial_load_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    LOAD   = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_load_sequencer_bit_counter.sv
// Accepted-bit counter for one frame: clears on frame start, counts enabled bits,
// saturates at WIDTH and flags when the count reaches WIDTH.
module serial_bit_counter
  import serial_load_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic clear,
  input  logic start_clr,
  input  logic cnt_en,
  output logic tc
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (start_clr) begin
      count_d = '0;
    end else if (cnt_en && (count_q != CW'(WIDTH))) begin
      count_d = count_q + 1'b1;
    end
  end

  // Flags the bit being accepted this cycle as the WIDTH-th one of the frame.
  assign tc = (count_d == CW'(WIDTH));

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_load_sequencer.sv
// Serial-to-parallel front end that writes assembled words into the load/clear register.
// Optional parity stage enabled by defining PARITY_CHECK_EN.
module serial_load_sequencer
  import serial_load_sequencer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             serial_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             load,
  output logic             busy,
  output logic             frame_err
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               load_q, load_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               start_clr;
  logic               cnt_en;
  logic               tc;
  logic [WIDTH-1:0]   shifted;

  serial_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk       (clk),
    .clear     (clear),
    .start_clr (start_clr),
    .cnt_en    (cnt_en),
    .tc        (tc)
  );

  assign shifted = MSB_FIRST ? ((shift_q << 1) | WIDTH'(serial_in))
                             : ((shift_q >> 1) | (WIDTH'(serial_in) << (WIDTH - 1)));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    data_d    = data_q;
    load_d    = 1'b0;
    err_d     = 1'b0;
    start_clr = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      IDLE: begin
        // busy_q is still high during a parity-error cycle, which sits in IDLE.
        if (start && !busy_q) begin
          state_d   = SHIFT;
          shift_d   = '0;
          start_clr = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          cnt_en  = 1'b1;
          shift_d = shifted;
          if (tc) begin
`ifdef PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d = LOAD;
            load_d  = 1'b1;
            data_d  = shifted;
`endif
          end
        end
      end
      PARITY: begin
`ifdef PARITY_CHECK_EN
        if (bit_valid) begin
          if ((^shift_q) ^ serial_in) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = LOAD;
            load_d  = 1'b1;
            data_d  = shift_q;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE) || err_d;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      shift_q <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign data_out  = data_q;
  assign load      = load_q;
  assign busy      = busy_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_serial_load_sequencer.sv
// Directed bench for serial_load_sequencer: LSB-first and MSB-first instances share stimulus.
// Build with +define+PARITY_CHECK_EN to exercise the parity stage.
module tb_serial_load_sequencer;

  logic       clk;
  logic       clear;
  logic       start;
  logic       serial_in;
  logic       bit_valid;
  logic [3:0] data_out, data_out_m;
  logic       load, load_m;
  logic       busy, busy_m;
  logic       frame_err, frame_err_m;

  int vectors     = 0;
  int miscompares = 0;
  int load_cnt    = 0;
  int err_cnt     = 0;

  serial_load_sequencer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut (
    .clk       (clk),
    .clear     (clear),
    .start     (start),
    .serial_in (serial_in),
    .bit_valid (bit_valid),
    .data_out  (data_out),
    .load      (load),
    .busy      (busy),
    .frame_err (frame_err)
  );

  serial_load_sequencer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk       (clk),
    .clear     (clear),
    .start     (start),
    .serial_in (serial_in),
    .bit_valid (bit_valid),
    .data_out  (data_out_m),
    .load      (load_m),
    .busy      (busy_m),
    .frame_err (frame_err_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load) load_cnt <= load_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  typedef struct {
    string      name;
    logic [3:0] seq;      // seq[0] is the first bit on the wire
    int         gap;
    logic [3:0] exp_lsb;
    logic [3:0] exp_msb;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Four back-to-back data bits, plus the even parity bit when the feature is built in.
  task automatic feed_bits(input logic [3:0] seq);
    for (int i = 0; i < 4; i++) begin
      serial_in = seq[i];
      bit_valid = 1'b1;
      tick();
    end
`ifdef PARITY_CHECK_EN
    serial_in = ^seq;
    tick();
`endif
    bit_valid = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic [3:0] seq, input int gap,
                           input logic [3:0] exp_lsb, input logic [3:0] exp_msb);
    int cnt0;
    bit gap_bad;
    cnt0    = load_cnt;
    gap_bad = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "_busy_start"}, busy, 1);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        bit_valid = 1'b0;
        tick();
        if (!busy || load) gap_bad = 1'b1;
      end
      serial_in = seq[i];
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
      if (i < 3 && (!busy || load)) gap_bad = 1'b1;
    end
`ifdef PARITY_CHECK_EN
    chk({name, "_no_load_before_parity"}, load, 0);
    serial_in = ^seq;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
`endif
    chk({name, "_load"}, load, 1);
    chk({name, "_data_lsb"}, data_out, exp_lsb);
    chk({name, "_data_msb"}, data_out_m, exp_msb);
    chk({name, "_busy_load"}, busy, 1);
    tick();
    chk({name, "_load_fall"}, load, 0);
    chk({name, "_busy_fall"}, busy, 0);
    chk({name, "_load_count"}, load_cnt - cnt0, 1);
    chk({name, "_gap_busy"}, gap_bad, 0);
    $display("frame %s: data_out=%b data_out_msb=%b loads=%0d", name, data_out, data_out_m,
             load_cnt - cnt0);
  endtask

  initial begin
    int cnt0;

    vecs[0] = '{name: "lsb_0101",   seq: 4'b1010, gap: 0, exp_lsb: 4'b1010, exp_msb: 4'b0101};
    vecs[1] = '{name: "gapped_1100", seq: 4'b0011, gap: 3, exp_lsb: 4'b0011, exp_msb: 4'b1100};
    vecs[2] = '{name: "msb_1010",   seq: 4'b0101, gap: 0, exp_lsb: 4'b0101, exp_msb: 4'b1010};
    vecs[3] = '{name: "ones_gap1",  seq: 4'b1111, gap: 1, exp_lsb: 4'b1111, exp_msb: 4'b1111};

    clear     = 1'b1;
    start     = 1'b1;
    serial_in = 1'b1;
    bit_valid = 1'b1;
    tick();
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    chk("reset_data", data_out, 0);
    chk("reset_load", load, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", frame_err, 0);
    clear = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].name, vecs[v].seq, vecs[v].gap, vecs[v].exp_lsb, vecs[v].exp_msb);
      tick();
    end

    // Bits in IDLE are ignored; data_out holds the last word.
    serial_in = 1'b0;
    bit_valid = 1'b1;
    tick();
    tick();
    bit_valid = 1'b0;
    chk("idle_hold_data", data_out, 4'b1111);
    chk("idle_busy", busy, 0);

    // Clear two bits into a frame: no load, data_out zeroed.
    cnt0  = load_cnt;
    start = 1'b1;
    tick();
    start     = 1'b0;
    serial_in = 1'b1;
    bit_valid = 1'b1;
    tick();
    tick();
    bit_valid = 1'b0;
    clear     = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_data", data_out, 0);
    chk("clear_busy", busy, 0);
    chk("clear_load", load, 0);
    tick();
    tick();
    chk("clear_no_load", load_cnt - cnt0, 0);
    $display("frame mid_clear: data_out=%b busy=%b", data_out, busy);
    run_frame("after_clear", 4'b1001, 0, 4'b1001, 4'b1001);
    tick();

    // Clear coinciding with the final data bit kills the pending load.
    cnt0  = load_cnt;
    start = 1'b1;
    tick();
    start     = 1'b0;
    serial_in = 1'b0;
    bit_valid = 1'b1;
    tick();
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear     = 1'b0;
    bit_valid = 1'b0;
    chk("clear_last_load", load, 0);
    chk("clear_last_data", data_out, 0);
    tick();
    tick();
    chk("clear_last_count", load_cnt - cnt0, 0);
    $display("frame clear_on_last: data_out=%b", data_out);

    // start held high through SHIFT and LOAD is ignored; start in the next IDLE cycle opens a frame.
    cnt0  = load_cnt;
    start = 1'b1;
    tick();
    chk("ign_busy", busy, 1);
    feed_bits(4'b1101);
    chk("ign_load", load, 1);
    chk("ign_data", data_out, 4'b1101);
    tick();
    chk("ign_idle_busy", busy, 0);
    chk("ign_idle_load", load, 0);
    tick();
    start = 1'b0;
    chk("ign_new_frame", busy, 1);
    chk("ign_single_load", load_cnt - cnt0, 1);
    feed_bits(4'b0000);
    chk("ign_second_load", load, 1);
    chk("ign_second_data", data_out, 4'b0000);
    tick();
    $display("frame ignored_start: loads=%0d data_out=%b", load_cnt - cnt0, data_out);
    tick();

`ifdef PARITY_CHECK_EN
    run_frame("par_good", 4'b1010, 0, 4'b1010, 4'b0101);
    tick();
    cnt0  = load_cnt;
    start = 1'b1;
    tick();
    start     = 1'b0;
    serial_in = 1'b1;
    bit_valid = 1'b1;
    tick();
    tick();
    tick();
    serial_in = 1'b0;
    tick();
    chk("par_wait_load", load, 0);
    chk("par_wait_busy", busy, 1);
    serial_in = 1'b0;
    tick();
    bit_valid = 1'b0;
    chk("par_err", frame_err, 1);
    chk("par_err_load", load, 0);
    chk("par_err_busy", busy, 1);
    chk("par_err_data", data_out, 4'b1010);
    tick();
    chk("par_err_fall", frame_err, 0);
    chk("par_err_idle", busy, 0);
    chk("par_err_no_load", load_cnt - cnt0, 0);
    $display("frame par_bad: frame_err_pulses=%0d data_out=%b", err_cnt, data_out);
`else
    chk("frame_err_tied", err_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
